// File: rtl/alu_logic_pipe_if.sv
// alu_logic_pipe_if -- request/result bus for alu_logic_pipe.
//   in_valid/in_ready/in_op/in_a/in_b : operation request handshake
//   out_valid/out_ready/out_data      : result handshake (head of result FIFO)
//   out_zero                          : head result is all-zero
//   op_count                          : count of accepted requests (wraps)
//   out_parity                        : XOR of head result, only when
//                                       ALU_LOGIC_PIPE_PARITY_EN is defined
// master = requester/consumer side, slave = the ALU pipe.
interface alu_logic_pipe_if #(
   parameter int WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       in_op;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic             out_zero;
   logic [15:0]      op_count;
`ifdef ALU_LOGIC_PIPE_PARITY_EN
   logic             out_parity;

   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_zero, op_count, out_parity
   );
   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_zero, op_count, out_parity
   );
`else
   modport master (
      output in_valid, in_op, in_a, in_b, out_ready,
      input  in_ready, out_valid, out_data, out_zero, op_count
   );
   modport slave (
      input  in_valid, in_op, in_a, in_b, out_ready,
      output in_ready, out_valid, out_data, out_zero, op_count
   );
`endif
endinterface

// File: rtl/alu_logic_pipe.sv
// alu_logic_pipe -- bitwise logic ALU feeding a small result FIFO.
// A request accepted on a rising edge (in_valid && in_ready) has its result
// computed combinationally and written to the FIFO tail on that edge; it is
// visible at the head (out_data, out_valid) from the following cycle.
// Ports:
//   clock   : sole clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : alu_logic_pipe_if.slave (request, result, op_count)
// Parameters: WIDTH (1..64) operand/result bits, DEPTH (1..16) FIFO entries.
//   WIDTH must match the WIDTH of the connected interface instance.
// Optional: define ALU_LOGIC_PIPE_PARITY_EN to add bus.out_parity, the
//   XOR-reduction of the head result, stored per FIFO entry.
module alu_logic_pipe #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic            clock,
   input  logic            reset_n,
   alu_logic_pipe_if.slave bus
);
   localparam int               PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int               CNT_W     = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   logic [CNT_W-1:0] count_reg;
   logic [PTR_W-1:0] wr_ptr_reg;
   logic [PTR_W-1:0] rd_ptr_reg;
   logic [15:0]      op_count_reg;
   logic [WIDTH-1:0] data_mem [DEPTH];
   logic [WIDTH-1:0] result_next;
   logic             not_empty;
   logic             ready;
   logic             push;
   logic             pop;

   // Ready depends only on occupancy: a pop in the same cycle does not make
   // room for a push while full.
   assign not_empty = (count_reg != '0);
   assign ready     = (count_reg < DEPTH_CNT);
   assign push      = bus.in_valid && ready;
   assign pop       = bus.out_ready && not_empty;

   always_comb begin
      result_next = '0;
      case (bus.in_op)
         3'b000:  result_next = ~bus.in_a;
         3'b001:  result_next = bus.in_a & bus.in_b;
         3'b010:  result_next = bus.in_a | bus.in_b;
         3'b011:  result_next = bus.in_a ^ bus.in_b;
         3'b100:  result_next = ~(bus.in_a & bus.in_b);
         3'b101:  result_next = ~(bus.in_a | bus.in_b);
         3'b110:  result_next = ~(bus.in_a ^ bus.in_b);
         default: result_next = bus.in_a;
      endcase
   end

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count_reg    <= '0;
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         op_count_reg <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg   <= ptr_inc(wr_ptr_reg);
            op_count_reg <= op_count_reg + 16'd1;
         end
         if (pop) begin
            rd_ptr_reg <= ptr_inc(rd_ptr_reg);
         end
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // Storage needs no reset: an entry is only visible once count covers it,
   // and reset clears count.
   always_ff @(posedge clock) begin
      if (push) begin
         data_mem[wr_ptr_reg] <= result_next;
      end
   end

   assign bus.in_ready  = ready;
   assign bus.out_valid = not_empty;
   assign bus.out_data  = not_empty ? data_mem[rd_ptr_reg] : '0;
   assign bus.out_zero  = not_empty && (data_mem[rd_ptr_reg] == '0);
   assign bus.op_count  = op_count_reg;

`ifdef ALU_LOGIC_PIPE_PARITY_EN
   logic parity_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (push) begin
         parity_mem[wr_ptr_reg] <= ^result_next;
      end
   end

   assign bus.out_parity = not_empty && parity_mem[rd_ptr_reg];
`endif

endmodule
